// File: rtl/reg_dump_tx_pkg.sv
// Shared LC-3 package: register-file geometry defaults and the register dump sequencer state type.
// CSUM is always in the enum so encodings do not change between builds.
package reg_dump_tx_pkg;

   localparam int unsigned NumRegsDefault = 8;
   localparam int unsigned DataWDefault   = 16;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StSend,
      StDone,
      StCsum
   } state_e;

endpackage

// File: rtl/reg_dump_tx.sv
// Walks the LC-3 register file through one read-select port and streams each register as a
// valid/ready word. Define REG_DUMP_CHECKSUM_EN to append a modulo-2^DATA_W checksum beat.
module reg_dump_tx
   import reg_dump_tx_pkg::*;
#(
   parameter int unsigned NUM_REGS = NumRegsDefault,
   parameter int unsigned DATA_W   = DataWDefault,
   parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic [IDX_W-1:0]  RD_IDX,
   input  logic [DATA_W-1:0] RD_DATA,
   output logic [DATA_W-1:0] Out_Data,
   output logic [IDX_W-1:0]  Out_Idx,
   output logic              Out_Last,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic              Busy,
   output logic              Done
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   hold_q, hold_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               idx_d   = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            hold_d  = RD_DATA;
            state_d = StSend;
         end
         StSend: begin
            if (Out_Ready) begin
               if (idx_q == LastIdx) begin
`ifdef REG_DUMP_CHECKSUM_EN
                  state_d = StCsum;
`else
                  state_d = StDone;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StFetch;
               end
            end
         end
`ifdef REG_DUMP_CHECKSUM_EN
         StCsum: begin
            if (Out_Ready) state_d = StDone;
         end
`endif
         StDone: begin
            // Index holds at the last register until the return to idle.
            idx_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
      end
   end

`ifdef REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == StIdle && Start) begin
         csum_d = '0;
      end else if (state_q == StSend && Out_Ready) begin
         csum_d = csum_q + hold_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) csum_q <= '0;
      else       csum_q <= csum_d;
   end

   assign Out_Data = (state_q == StCsum) ? csum_q : hold_q;
   assign Out_Last = (state_q == StCsum);
`else
   assign Out_Data = hold_q;
   assign Out_Last = (state_q == StSend) && (idx_q == LastIdx);
`endif

   assign RD_IDX    = idx_q;
   assign Out_Idx   = (state_q == StCsum) ? '0 : idx_q;
   assign Out_Valid = (state_q == StSend) || (state_q == StCsum);
   assign Busy      = (state_q != StIdle);
   assign Done      = (state_q == StDone);

endmodule
